// File: rtl/locked_reg_reader.sv
// Single-outstanding register read port with per-register lock, debug override,
// scan-mode data suppression and a saturating lock-violation counter.
module locked_reg_reader (
  input  logic        Clk,
  input  logic        resetn,
  input  logic        rd_req,
  input  logic [1:0]  rd_addr,
  input  logic [63:0] reg_bank,
  input  logic [3:0]  lock_status,
  input  logic        scan_mode,
  input  logic        debug_unlocked,
  input  logic        viol_clr,
  output logic        busy,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic [7:0]  viol_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                lock_q;
  logic                scan_q;
  logic                dbg_q;

  logic [DATA_W-1:0]   sel_data_c;
  logic                sel_lock_c;
  logic                viol_now_c;
  logic                deny_c;

  // Register/lock selection for the latched address
  assign sel_data_c = reg_bank[{addr_q, 4'b0000} +: DATA_W];
  assign sel_lock_c = lock_status[addr_q];
  // Violation is judged on the same inputs that are being sampled into FETCH registers
  assign viol_now_c = (state == FETCH) && !scan_mode && sel_lock_c && !debug_unlocked;
  assign deny_c     = scan_q | (lock_q & ~dbg_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_req) state_next = FETCH;
      FETCH:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Address captured on accept, access context captured on FETCH exit
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      data_q <= '0;
      lock_q <= 1'b0;
      scan_q <= 1'b0;
      dbg_q  <= 1'b0;
    end else begin
      if (state == IDLE && rd_req) addr_q <= rd_addr;
      if (state == FETCH) begin
        data_q <= sel_data_c;
        lock_q <= sel_lock_c;
        scan_q <= scan_mode;
        dbg_q  <= debug_unlocked;
      end
    end
  end

  // Response is presented for the one cycle after leaving RESP; zero otherwise
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      busy     <= (state_next != IDLE);
      rd_valid <= (state == RESP);
      rd_err   <= (state == RESP) && deny_c;
      rd_data  <= ((state == RESP) && !deny_c) ? data_q : '0;
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn)                                  viol_count <= '0;
    else if (viol_clr)                            viol_count <= '0;
    else if (viol_now_c && viol_count != CNT_MAX) viol_count <= viol_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_locked_reg_reader.sv
// Directed bench for locked_reg_reader: vector table of single reads plus
// back-to-back, saturation/clear and mid-transaction reset sequences.
module tb_locked_reg_reader;

  logic        Clk;
  logic        resetn;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic [63:0] reg_bank;
  logic [3:0]  lock_status;
  logic        scan_mode;
  logic        debug_unlocked;
  logic        viol_clr;
  logic        busy;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_err;
  logic [7:0]  viol_count;

  int checks;
  int failures;

  localparam logic [63:0] BANK = {16'h0F0F, 16'hBEEF, 16'hA5C3, 16'h1234};

  typedef struct {
    logic [1:0]  addr;
    logic [3:0]  lock;
    logic        scan;
    logic        dbg;
    logic [15:0] data;
    logic        err;
    logic [7:0]  viol;
  } vec_t;

  vec_t vecs[8];

  locked_reg_reader dut (
    .Clk            (Clk),
    .resetn         (resetn),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .reg_bank       (reg_bank),
    .lock_status    (lock_status),
    .scan_mode      (scan_mode),
    .debug_unlocked (debug_unlocked),
    .viol_clr       (viol_clr),
    .busy           (busy),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_err         (rd_err),
    .viol_count     (viol_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One complete read; optionally disturbs the access context after the FETCH sample
  task automatic do_read(input string name, input logic [1:0] a, input logic [15:0] exp_d,
                         input logic exp_e, input logic [7:0] exp_v, input logic scramble);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req  = 1'b0;
    rd_addr = ~a;
    check({name, " busy_fetch"}, 32'(busy), 32'd1);
    tick();
    check({name, " busy_resp"}, 32'(busy), 32'd1);
    check({name, " early_valid"}, 32'(rd_valid), 32'd0);
    check({name, " viol"}, 32'(viol_count), 32'(exp_v));
    if (scramble) begin
      reg_bank       = ~reg_bank;
      lock_status    = ~lock_status;
      scan_mode      = ~scan_mode;
      debug_unlocked = ~debug_unlocked;
    end
    tick();
    check({name, " valid"}, 32'(rd_valid), 32'd1);
    check({name, " data"}, 32'(rd_data), 32'(exp_d));
    check({name, " err"}, 32'(rd_err), 32'(exp_e));
    check({name, " busy_done"}, 32'(busy), 32'd0);
    tick();
    check({name, " valid_off"}, 32'(rd_valid), 32'd0);
    check({name, " data_off"}, 32'({rd_err, rd_data}), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    rd_req = 1'b0;
    rd_addr = 2'd0;
    reg_bank = BANK;
    lock_status = 4'b0000;
    scan_mode = 1'b0;
    debug_unlocked = 1'b0;
    viol_clr = 1'b0;

    vecs[0] = '{addr: 2'd1, lock: 4'b0000, scan: 1'b0, dbg: 1'b0, data: 16'hA5C3, err: 1'b0, viol: 8'd0};
    vecs[1] = '{addr: 2'd2, lock: 4'b0100, scan: 1'b0, dbg: 1'b0, data: 16'h0000, err: 1'b1, viol: 8'd1};
    vecs[2] = '{addr: 2'd2, lock: 4'b0100, scan: 1'b0, dbg: 1'b1, data: 16'hBEEF, err: 1'b0, viol: 8'd1};
    vecs[3] = '{addr: 2'd2, lock: 4'b0100, scan: 1'b1, dbg: 1'b0, data: 16'h0000, err: 1'b1, viol: 8'd1};
    vecs[4] = '{addr: 2'd3, lock: 4'b1111, scan: 1'b1, dbg: 1'b1, data: 16'h0000, err: 1'b1, viol: 8'd1};
    vecs[5] = '{addr: 2'd0, lock: 4'b1110, scan: 1'b0, dbg: 1'b0, data: 16'h1234, err: 1'b0, viol: 8'd1};
    vecs[6] = '{addr: 2'd3, lock: 4'b1000, scan: 1'b0, dbg: 1'b0, data: 16'h0000, err: 1'b1, viol: 8'd2};
    vecs[7] = '{addr: 2'd3, lock: 4'b0111, scan: 1'b0, dbg: 1'b0, data: 16'h0F0F, err: 1'b0, viol: 8'd2};

    #3;
    check("reset_outputs", 32'({busy, rd_valid, rd_err, rd_data, viol_count}), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    resetn = 1'b1;
    #4;

    for (int i = 0; i < 8; i++) begin
      reg_bank       = BANK;
      lock_status    = vecs[i].lock;
      scan_mode      = vecs[i].scan;
      debug_unlocked = vecs[i].dbg;
      do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].viol, 1'b1);
    end
    reg_bank = BANK;

    // Back-to-back: rd_req held 6 cycles, lock toggled in each RESP
    lock_status    = 4'b0100;
    scan_mode      = 1'b0;
    debug_unlocked = 1'b0;
    rd_addr        = 2'd2;
    for (int i = 1; i <= 10; i++) begin
      rd_req = (i <= 6);
      tick();
      check($sformatf("b2b valid c%0d", i), 32'(rd_valid), 32'((i == 3) || (i == 6)));
      if (i == 3) check("b2b first resp", 32'({rd_err, rd_data}), 32'h10000);
      if (i == 6) check("b2b second resp", 32'({rd_err, rd_data}), 32'h0BEEF);
      if (i == 2) lock_status = 4'b0000;
      if (i == 5) lock_status = 4'b0100;
    end
    check("b2b viol", 32'(viol_count), 32'd3);

    // 260 locked reads saturate the counter
    lock_status = 4'b1111;
    rd_addr     = 2'd0;
    rd_req      = 1'b1;
    repeat (780) tick();
    rd_req = 1'b0;
    check("sat value", 32'(viol_count), 32'hFF);
    tick();
    tick();
    check("sat hold", 32'(viol_count), 32'hFF);

    // Clear coincident with a violating RESP entry
    rd_req = 1'b1;
    tick();
    rd_req   = 1'b0;
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    check("clr wins", 32'(viol_count), 32'd0);
    tick();
    check("clr resp", 32'({rd_valid, rd_err, rd_data}), 32'h30000);
    tick();
    do_read("after_clr", 2'd1, 16'h0000, 1'b1, 8'd1, 1'b0);

    // Reset pulse during FETCH
    lock_status = 4'b0000;
    rd_req  = 1'b1;
    rd_addr = 2'd3;
    tick();
    rd_req = 1'b0;
    check("pre_rst busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async rst outputs", 32'({busy, rd_valid, rd_err, rd_data, viol_count}), 32'd0);
    #2 resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst idle c%0d", i), 32'({busy, rd_valid, rd_err, rd_data}), 32'd0);
    end
    do_read("first_after_rst", 2'd3, 16'h0F0F, 1'b0, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
